// File: rtl/pwm_seq_pkg.sv
// Shared constants, FSM state type and COMP stepping helper for the PWM ramp sequencer.
package pwm_seq_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [7:0] OFF_DIV   = 8'h30;
  localparam logic [7:0] OFF_COMP  = 8'h34;
  localparam logic [7:0] OFF_STATE = 8'h38;
  localparam logic [7:0] OFF_CNT   = 8'h3C;

  localparam logic [DATA_W-1:0] STATE_START = 32'h1;
  localparam logic [DATA_W-1:0] STATE_OFF   = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DIV,
    ST_WR_COMP,
    ST_WR_STATE,
    ST_WAIT,
    ST_WR_OFF
  } state_t;

  // Move cur one step toward endv, clamping at endv; the 33-bit sum cannot wrap.
  function automatic logic [DATA_W-1:0] next_comp(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] endv,
                                                  input logic [DATA_W-1:0] step);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] gap;
    sum = '0;
    gap = '0;
    if (endv >= cur) begin
      sum = {1'b0, cur} + {1'b0, step};
      next_comp = (sum > {1'b0, endv}) ? endv : sum[DATA_W-1:0];
    end else begin
      gap = cur - endv;
      next_comp = (step >= gap) ? endv : cur - step;
    end
  endfunction

endpackage

// File: rtl/pwm_seq_if.sv
// APB write-only bus between the ramp sequencer (master) and the PWM slave.
interface pwm_seq_if;
  import pwm_seq_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;

  modport master (output psel, penable, pwrite, paddr, pwdata);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata);
endinterface

// File: rtl/apb_wr_master.sv
// Single APB write engine: req loads SETUP, next cycle is ACCESS (ack_c); req during ACCESS chains.
module apb_wr_master
  import pwm_seq_pkg::*;
(
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              req,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ack_c,
  pwm_seq_if.master         m
);

  assign ack_c = m.psel & m.penable;

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      m.psel    <= 1'b0;
      m.penable <= 1'b0;
      m.pwrite  <= 1'b0;
      m.paddr   <= '0;
      m.pwdata  <= '0;
    end else if (req) begin
      m.psel    <= 1'b1;
      m.penable <= 1'b0;
      m.pwrite  <= 1'b1;
      m.paddr   <= addr;
      m.pwdata  <= data;
    end else if (m.psel && !m.penable) begin
      m.penable <= 1'b1;
    end else if (m.psel && m.penable) begin
      m.psel    <= 1'b0;
      m.penable <= 1'b0;
      m.pwrite  <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Sequences the PWM peripheral through DIV/COMP/STATE setup and a stepped COMP ramp over APB.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              apb_pclk,
  input  logic              apb_prstn,
  input  logic              go,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_div,
  input  logic [DATA_W-1:0] cfg_comp_start,
  input  logic [DATA_W-1:0] cfg_comp_end,
  input  logic [DATA_W-1:0] cfg_step,
  input  logic [CNT_W-1:0]  cfg_interval,
  pwm_seq_if.master         m,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] cur_comp
);

  state_t            state, state_n;
  logic [DATA_W-1:0] end_q, end_n, step_q, step_n, first_q, first_n;
  logic [DATA_W-1:0] comp_q, comp_n, cur_n;
  logic [CNT_W-1:0]  intv_q, intv_n, cnt_q, cnt_n;
  logic              first_pass_q, first_pass_n, pend_q, pend_n;
  logic              busy_n, done_n;
  logic              req_c, ack_c, abort_any_c;
  logic [DATA_W-1:0] addr_c, data_c;

  function automatic logic [DATA_W-1:0] reg_addr(input logic [7:0] off);
    return BASE_ADDR + 32'(off);
  endfunction

  apb_wr_master u_wr (
    .apb_pclk  (apb_pclk),
    .apb_prstn (apb_prstn),
    .req       (req_c),
    .addr      (addr_c),
    .data      (data_c),
    .ack_c     (ack_c),
    .m         (m)
  );

  assign abort_any_c = abort | pend_q;

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      state        <= ST_IDLE;
      end_q        <= '0;
      step_q       <= '0;
      first_q      <= '0;
      intv_q       <= '0;
      cnt_q        <= '0;
      comp_q       <= '0;
      cur_comp     <= '0;
      first_pass_q <= 1'b0;
      pend_q       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      end_q        <= end_n;
      step_q       <= step_n;
      first_q      <= first_n;
      intv_q       <= intv_n;
      cnt_q        <= cnt_n;
      comp_q       <= comp_n;
      cur_comp     <= cur_n;
      first_pass_q <= first_pass_n;
      pend_q       <= pend_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

  // Next-state and write-request logic; an abort seen mid-write is held until that ACCESS.
  always_comb begin
    state_n      = state;
    end_n        = end_q;
    step_n       = step_q;
    first_n      = first_q;
    intv_n       = intv_q;
    cnt_n        = cnt_q;
    comp_n       = comp_q;
    cur_n        = cur_comp;
    first_pass_n = first_pass_q;
    pend_n       = pend_q;
    done_n       = 1'b0;
    req_c        = 1'b0;
    addr_c       = '0;
    data_c       = '0;

    case (state)
      ST_IDLE: begin
        pend_n = 1'b0;
        if (go && !abort) begin
          end_n        = cfg_comp_end;
          step_n       = cfg_step;
          first_n      = (cfg_step == '0) ? cfg_comp_end : cfg_comp_start;
          intv_n       = (cfg_interval == '0) ? CNT_W'(1) : cfg_interval;
          first_pass_n = 1'b1;
          req_c        = 1'b1;
          addr_c       = reg_addr(OFF_DIV);
          data_c       = cfg_div;
          state_n      = ST_WR_DIV;
        end
      end
      ST_WR_DIV, ST_WR_COMP, ST_WR_STATE: begin
        pend_n = abort_any_c;
        if (ack_c) begin
          if (state == ST_WR_COMP) cur_n = comp_q;
          if (abort_any_c) begin
            req_c   = 1'b1;
            addr_c  = reg_addr(OFF_STATE);
            data_c  = STATE_OFF;
            pend_n  = 1'b0;
            state_n = ST_WR_OFF;
          end else if (state == ST_WR_DIV) begin
            req_c   = 1'b1;
            addr_c  = reg_addr(OFF_COMP);
            data_c  = first_q;
            comp_n  = first_q;
            state_n = ST_WR_COMP;
          end else if (state == ST_WR_COMP && first_pass_q) begin
            req_c        = 1'b1;
            addr_c       = reg_addr(OFF_STATE);
            data_c       = STATE_START;
            first_pass_n = 1'b0;
            state_n      = ST_WR_STATE;
          end else if (cur_n == end_q) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            cnt_n   = intv_q;
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          req_c   = 1'b1;
          addr_c  = reg_addr(OFF_STATE);
          data_c  = STATE_OFF;
          state_n = ST_WR_OFF;
        end else if (cnt_q <= CNT_W'(1)) begin
          req_c   = 1'b1;
          addr_c  = reg_addr(OFF_COMP);
          data_c  = next_comp(cur_comp, end_q, step_q);
          comp_n  = data_c;
          state_n = ST_WR_COMP;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_OFF: begin
        pend_n = 1'b0;
        if (ack_c) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule
